bram_capture_writer: RTL and testbench
======================================

Name: bram_capture_writer

Overview:
- Captures a stream of DSP-domain data words and writes them into one PS-visible BRAM write port in the dspclk domain.
- Uses a byte address, a full-width byte-enable and a 256-bit data word.
- Sits directly upstream of the BRAM write bram_map instances. Its bram_* outputs drive one bram_write interface; the PS reads the captured buffer back over AXI.
- Arm, trigger, length and status are driven from the DSP register bank over the local bus.

Parameters:
- ADDR_WIDTH, 32, BRAM byte-address width.
- DATA_WIDTH, 256, data word width; must be a power of two and at least 8.
- LEN_WIDTH, 12, width of the word-count fields; maximum capture is 2^LEN_WIDTH-1 words.

Ports:
- dspclk  input  1  single clock for all logic.
- dspresetn  input  1  synchronous, active-low reset.
- arm  input  1  single-cycle pulse: load configuration and wait for trigger.
- abort  input  1  single-cycle pulse: stop the capture and return to IDLE.
- trigger  input  1  starts the capture while ARMED.
- base_addr  input  ADDR_WIDTH  byte address of the first word; must be aligned to DATA_WIDTH/8.
- nwords  input  LEN_WIDTH  number of words to capture; 0 means no capture.
- din_valid  input  1  input data qualifier.
- din  input  DATA_WIDTH  input data word.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  sticky; set when a capture completes.
- overflow  output  1  sticky; set on an abort during CAPTURE.
- wcount  output  LEN_WIDTH  number of words written in the current or most recent capture.
- bram_clk  output  1  equal to dspclk.
- bram_rst  output  1  equal to ~dspresetn.
- bram_addr  output  ADDR_WIDTH  BRAM byte address.
- bram_din  output  DATA_WIDTH  BRAM write data.
- bram_en  output  1  BRAM enable.
- bram_we  output  DATA_WIDTH/8  BRAM byte write enables.

Behaviour:
- Reset, sampled on the dspclk rising edge while dspresetn=0:
  - state=IDLE.
  - busy=0, done=0, overflow=0, wcount=0.
  - bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
- State IDLE:
  - arm=1 latches base_addr and nwords and clears done, overflow and wcount.
  - If the latched nwords=0: set done, stay in IDLE.
  - Otherwise go to ARMED.
  - arm is ignored in any other state.
- State ARMED:
  - trigger=1 goes to CAPTURE. The din_valid/din presented in the same cycle as the trigger is the first accepted word.
  - abort=1 goes to IDLE; done and overflow are unchanged.
- State CAPTURE:
  - Every cycle with din_valid=1 accepts one word.
  - Accepted word k (0-based) appears on the BRAM port exactly 1 cycle later:
    - bram_en=1 and bram_we=all ones.
    - bram_din=din.
    - bram_addr=latched base_addr + k*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH (wraps silently).
  - wcount increments in the same cycle the write is presented.
  - In cycles with no write, bram_en=0 and bram_we=0; bram_addr and bram_din hold their last values.
  - When the accepted word is word nwords-1: go to IDLE; done is set in the cycle its write is presented.
  - din_valid is ignored outside CAPTURE.
  - abort in CAPTURE:
    - Go to IDLE and set overflow; done stays 0.
    - A word accepted in the previous cycle still completes its write.
    - A word presented in the abort cycle is dropped.
- Simultaneous events:
  - abort has priority over trigger and din_valid.
  - arm together with abort in IDLE: arm wins.
- Status outputs:
  - busy is combinational from state.
  - done and overflow hold until the next accepted arm or reset.
  - wcount never exceeds the latched nwords.
- Reset mid-capture: everything returns to reset values on the next edge, including bram_en=0. A pending pipelined write is discarded.
- Throughput: 1 word per cycle sustained. The block never stalls din; there is no ready signal.

Test Plan:
- Reset, then arm with base_addr=0x1000, nwords=4; trigger; din_valid=1 for 4 cycles with din=1,2,3,4 -> 4 writes at addresses 0x1000, 0x1020, 0x1040, 0x1060 with bram_we=32'hFFFFFFFF and data 1..4. Each write lags its input word by 1 cycle. done=1 on the 4th write, wcount=4, busy=0 afterwards.
- Gapped input: nwords=3, din_valid pattern 1,0,0,1,1 -> exactly 3 writes at consecutive addresses, bram_en=0 during the gap cycles, done only after the 3rd write.
- Abort after 2 of 8 words -> overflow=1, done=0, wcount=2, no further bram_en; a following arm clears overflow.
- nwords=0 arm -> done=1 in the next cycle, busy never asserted, no bram_en.
- Wrap-around: base_addr=0xFFFFFFE0, nwords=2 -> writes at 0xFFFFFFE0 then 0x00000000.
- dspresetn=0 asserted mid-capture and din_valid held high -> all outputs at reset values the next cycle; trigger after release has no effect until a new arm.

Source files
------------

// File: rtl/bram_capture_writer.sv
// Captures a DSP-domain word stream into one BRAM write port: arm/trigger/abort control,
// one registered write per accepted word, sticky done/overflow status.
module bram_capture_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                    dspclk,
    input  logic                    dspresetn,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    trigger,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0]    nwords,
    input  logic                    din_valid,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [LEN_WIDTH-1:0]    wcount,
    output logic                    bram_clk,
    output logic                    bram_rst,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_din,
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we
);
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   next_addr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    nwords_q;
    logic [LEN_WIDTH-1:0]    wcount_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    en_q;
    logic                    accept_d;
    logic                    last_d;

    // The trigger cycle's word counts; abort beats both trigger and din_valid.
    always_comb begin
        accept_d = din_valid && !abort &&
                   ((state_q == ARMED && trigger) || state_q == CAPTURE);
        last_d   = (wcount_q == nwords_q - LEN_WIDTH'(1));
    end

    always_ff @(posedge dspclk) begin
        if (!dspresetn) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            addr_q      <= '0;
            nwords_q    <= '0;
            wcount_q    <= '0;
            din_q       <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                IDLE: if (arm) begin
                    next_addr_q <= base_addr;
                    nwords_q    <= nwords;
                    done_q      <= (nwords == '0);
                    ovf_q       <= 1'b0;
                    wcount_q    <= '0;
                    if (nwords != '0) state_q <= ARMED;
                end
                ARMED: begin
                    if (abort)        state_q <= IDLE;
                    else if (trigger) state_q <= CAPTURE;
                end
                CAPTURE: if (abort) begin
                    state_q <= IDLE;
                    ovf_q   <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            // wcount is the accepted-word index, so it also selects the final word.
            if (accept_d) begin
                en_q        <= 1'b1;
                addr_q      <= next_addr_q;
                din_q       <= din;
                next_addr_q <= next_addr_q + ADDR_WIDTH'(BYTES);
                wcount_q    <= wcount_q + LEN_WIDTH'(1);
                if (last_d) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign wcount    = wcount_q;
    assign bram_clk  = dspclk;
    assign bram_rst  = ~dspresetn;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign bram_en   = en_q;
    assign bram_we   = {BYTES{en_q}};
endmodule

// File: tb/tb_bram_capture_writer.sv
// Directed + random stimulus for bram_capture_writer, checked every cycle against a
// transaction-level reference model of the capture rules.
module tb_bram_capture_writer;
    localparam int AW = 32, DW = 256, LW = 12;

    logic            dspclk = 1'b0, dspresetn = 1'b0;
    logic            arm = 0, abort = 0, trigger = 0, din_valid = 0;
    logic [AW-1:0]   base_addr = '0;
    logic [LW-1:0]   nwords = '0;
    logic [DW-1:0]   din = '0;
    logic            busy, done, overflow, bram_clk, bram_rst, bram_en;
    logic [LW-1:0]   wcount;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_din;
    logic [DW/8-1:0] bram_we;

    bram_capture_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .dspclk(dspclk), .dspresetn(dspresetn), .arm(arm), .abort(abort),
        .trigger(trigger), .base_addr(base_addr), .nwords(nwords),
        .din_valid(din_valid), .din(din), .busy(busy), .done(done),
        .overflow(overflow), .wcount(wcount), .bram_clk(bram_clk),
        .bram_rst(bram_rst), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_en(bram_en), .bram_we(bram_we));

    always #5 dspclk = ~dspclk;

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a capture session is (mode, base, length, words taken so far).
    int            m_mode;   // 0 idle, 1 waiting for trigger, 2 capturing
    logic [AW-1:0] m_base, e_addr;
    int            m_n, m_k;
    logic          m_done, m_ovf, e_en;
    logic [DW-1:0] e_din;
    int            n_writes;

    task automatic model_reset();
        m_mode = 0; m_base = '0; m_n = 0; m_k = 0;
        m_done = 0; m_ovf = 0; e_en = 0; e_addr = '0; e_din = '0;
    endtask

    task automatic model_step();
        bit take;
        take = 0;
        e_en = 0;
        if (!dspresetn) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            if (arm) begin
                m_base = base_addr; m_n = int'(nwords); m_k = 0;
                m_ovf = 0; m_done = (m_n == 0);
                if (m_n != 0) m_mode = 1;
            end
        end else if (abort) begin
            if (m_mode == 2) m_ovf = 1;
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (trigger) begin m_mode = 2; take = din_valid; end
        end else begin
            take = din_valid;
        end
        if (take) begin
            e_en = 1; e_din = din;
            e_addr = m_base + AW'(m_k * (DW / 8));
            m_k++;
            n_writes++;
            if (m_k == m_n) begin m_done = 1; m_mode = 0; end
        end
    endtask

    task automatic check_all();
        chk("busy", DW'(busy), DW'(m_mode != 0));
        chk("done", DW'(done), DW'(m_done));
        chk("overflow", DW'(overflow), DW'(m_ovf));
        chk("wcount", DW'(wcount), DW'(m_k));
        chk("bram_en", DW'(bram_en), DW'(e_en));
        chk("bram_we", DW'(bram_we), e_en ? DW'({(DW/8){1'b1}}) : '0);
        chk("bram_addr", DW'(bram_addr), DW'(e_addr));
        chk("bram_din", bram_din, e_din);
        chk("bram_rst", DW'(bram_rst), DW'(!dspresetn));
        chk("bram_clk", DW'(bram_clk), DW'(dspclk));
    endtask

    task automatic cyc(input logic rn, input logic a, input logic ab, input logic tr,
                       input logic [AW-1:0] ba, input logic [LW-1:0] nw,
                       input logic v, input logic [DW-1:0] d);
        @(negedge dspclk);
        dspresetn = rn; arm = a; abort = ab; trigger = tr;
        base_addr = ba; nwords = nw; din_valid = v; din = d;
        @(posedge dspclk);
        #1;
        model_step();
        check_all();
    endtask

    function automatic logic [DW-1:0] rword();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        model_reset();
        n_writes = 0;
        // reset
        cyc(0, 0, 0, 0, '0, '0, 0, '0);
        cyc(0, 0, 0, 0, '0, '0, 1, '1);
        // basic 4-word capture
        cyc(1, 1, 0, 0, 32'h1000, 12'd4, 0, '0);
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(1));
        for (int i = 2; i <= 4; i++) cyc(1, 0, 0, 0, '0, '0, 1, DW'(i));
        chk("basic_last_addr", DW'(bram_addr), DW'(32'h1060));
        chk("basic_done", DW'(done), DW'(1));
        cyc(1, 0, 0, 0, '0, '0, 1, DW'(9));
        chk("basic_wcount", DW'(wcount), DW'(4));
        chk("basic_idle", DW'(busy), DW'(0));
        // gapped input, 3 words
        cyc(1, 1, 0, 0, 32'h2000, 12'd3, 0, '0);
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(11));
        cyc(1, 0, 0, 0, '0, '0, 0, DW'(12));
        cyc(1, 0, 0, 0, '0, '0, 0, DW'(13));
        cyc(1, 0, 0, 0, '0, '0, 1, DW'(14));
        chk("gap_not_done", DW'(done), DW'(0));
        cyc(1, 0, 0, 0, '0, '0, 1, DW'(15));
        chk("gap_addr3", DW'(bram_addr), DW'(32'h2040));
        cyc(1, 0, 0, 0, '0, '0, 0, '0);
        // abort after 2 of 8, word in abort cycle dropped
        cyc(1, 1, 0, 0, 32'h3000, 12'd8, 0, '0);
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(21));
        cyc(1, 0, 0, 0, '0, '0, 1, DW'(22));
        cyc(1, 0, 1, 0, '0, '0, 1, DW'(23));
        chk("abort_ovf", DW'(overflow), DW'(1));
        chk("abort_wcount", DW'(wcount), DW'(2));
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, '0, '0, 1, DW'(24));
        // re-arm clears overflow, then zero-length arm
        cyc(1, 1, 1, 0, 32'h4000, 12'd0, 1, '0);
        chk("zero_done", DW'(done), DW'(1));
        chk("zero_ovf_clr", DW'(overflow), DW'(0));
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(5));
        // address wrap
        cyc(1, 1, 0, 0, 32'hFFFF_FFE0, 12'd2, 0, '0);
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(31));
        cyc(1, 0, 0, 0, '0, '0, 1, DW'(32));
        chk("wrap_addr", DW'(bram_addr), DW'(0));
        // reset mid-capture, then trigger without arm
        cyc(1, 1, 0, 0, 32'h5000, 12'd10, 0, '0);
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(41));
        cyc(1, 0, 0, 0, '0, '0, 1, DW'(42));
        cyc(0, 0, 0, 0, '0, '0, 1, DW'(43));
        chk("rst_en", DW'(bram_en), DW'(0));
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(44));
        cyc(1, 0, 0, 1, '0, '0, 1, DW'(45));
        // random
        for (int i = 0; i < 4000; i++) begin
            logic [AW-1:0] ba;
            logic [LW-1:0] nw;
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | AW'($urandom_range(0, 255)))
                                             : AW'($urandom);
            ba = ba & ~AW'(DW / 8 - 1);
            nw = ($urandom_range(0, 9) == 0) ? LW'(0) : LW'($urandom_range(1, 12));
            if ($urandom_range(0, 200) == 0) nw = LW'($urandom_range(100, 4095));
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 4) == 0),
                ba, nw,
                ($urandom_range(0, 9) < 7),
                rword());
        end
        chk("writes_seen", DW'(n_writes > 100), DW'(1));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
